inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch stage of the CPU24 single-issue core.
- Owns the program counter and drives the word address of the combinational instruction ROM (1024 x 32).
- Captures the returned instruction into the IF/ID pipeline register, together with PC+4 and a valid bit.
- Handles stalls, branch/jump redirects and halt (syscall) from downstream stages, and keeps a retired-fetch counter for the benchmark display.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- ADDR_W, 10, ROM word-address width. The ROM depth is 2^ADDR_W words.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  ADDR_W  ROM word address, equal to pc[ADDR_W+1:2]. Combinational from the PC register.
- rom_data  in  32  instruction word returned combinationally by the ROM in the same cycle.
- stall  in  1  hold request from decode/hazard unit. Freezes the PC and IF/ID.
- redirect  in  1  branch/jump taken; the target is on redirect_pc.
- redirect_pc  in  32  byte target address. Bits [1:0] are ignored (forced to 0).
- halt  in  1  syscall-halt request from decode. Single-cycle pulse or level.
- pc  out  32  current fetch PC (byte address).
- if_id_instr  out  32  latched instruction. Reads 32'h0 (nop) when not valid.
- if_id_pc4  out  32  PC+4 of the latched instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch is stopped in the HALT state.
- fetch_count  out  32  number of instructions latched with valid=1.

Behaviour:
- Reset (rst=1 at an edge) overrides everything:
  - pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, halted=0, fetch_count=0, state=RUN.
  - Reset mid-operation discards IF/ID contents immediately.
- State machine has two states, RUN and HALT.
  - RUN -> HALT when halt=1 at an edge (any other inputs).
  - HALT -> RUN only via rst.
  - halted = (state==HALT), registered.
- In RUN, each edge is resolved with priority halt > redirect > stall > normal.
  - halt: pc unchanged; IF/ID <= bubble (instr=0, valid=0, pc4 unchanged); fetch_count unchanged.
  - redirect: pc <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble (squashes the wrong-path fetch). Redirect wins over a simultaneous stall.
  - stall (no redirect): pc, IF/ID and fetch_count hold their values.
  - normal: pc <= pc+4; if_id_instr <= rom_data; if_id_pc4 <= pc+4; if_id_valid <= 1; fetch_count <= fetch_count+1.
- In HALT: pc, fetch_count and if_id_pc4 frozen; if_id_valid=0; if_id_instr=0. stall and redirect are ignored.
- Latency: the instruction at address A appears on if_id_instr one edge after pc==A, provided the cycle is not stalled or redirected.
- Arithmetic:
  - pc+4 is 32-bit modulo 2^32.
  - rom_addr takes pc[ADDR_W+1:2], so the ROM index wraps naturally. Example: pc 0x0000_0FFC -> 0x0000_1000 gives rom_addr 1023 -> 0.
  - fetch_count wraps modulo 2^32 (no saturation).
- rom_addr is a pure function of the pc register, with no combinational path from stall, redirect or halt.
- Invariant: if_id_instr is 0 whenever if_id_valid=0.

Test Plan:
- Reset + free run: ROM[0..3] = 0x2001_0005, 0x2002_000A, 0x0022_1820, 0x0000_000C. Hold rst 2 cycles, release. Expect:
  - rom_addr 0,1,2,3 on consecutive cycles.
  - if_id_instr 0x2001_0005 with pc4 4, then 0x2002_000A with pc4 8.
  - fetch_count reaches 3 after 3 edges.
- Stall: assert stall for 3 cycles while pc=0x8. Expect pc stays 0x8, IF/ID holds 0x2002_000A/pc4 8, and fetch_count is constant. After release, the next edge latches ROM[2] with pc4 0xC.
- Redirect, with and without stall:
  - At pc=0x10, pulse redirect with redirect_pc=0x0000_0043. Expect pc=0x40 next cycle, IF/ID bubble (valid=0, instr=0), and ROM[16] latched one edge later.
  - Repeat with stall=1 in the same cycle. Identical result expected.
- Halt: pulse halt=1 together with redirect=1 at pc=0x20. Expect:
  - halted=1 and pc stays 0x20.
  - valid stays 0 for 10+ cycles despite stall/redirect toggles.
  - fetch_count frozen.
  - rst returns to pc=0, halted=0.
- Wrap: redirect to 0x0000_0FFC, then run 2 cycles. Expect rom_addr 1023 then 0, pc 0x0000_1000, and if_id_pc4 0x0000_1000 for the ROM[1023] instruction.
- Reset mid-stream: assert rst during stall with valid=1 and fetch_count=5. The next edge gives pc=RESET_PC, valid=0, instr=0, fetch_count=0, halted=0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage for the CPU24 core: owns the PC, addresses the instruction ROM
// and fills the IF/ID register while honouring halt, redirect and stall from downstream.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 10
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   input  logic              halt,
   output logic [31:0]       pc,
   output logic [31:0]       if_id_instr,
   output logic [31:0]       if_id_pc4,
   output logic              if_id_valid,
   output logic              halted,
   output logic [31:0]       fetch_count
);

   typedef enum logic {RUN, HALT} state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc4;
   logic        r_valid;
   logic [31:0] r_fetchCount;
   logic [31:0] w_pcPlus4;
   logic [31:0] w_redirectPc;

   assign w_pcPlus4    = r_pc + 32'd4;
   // Low target bits are masked so the PC can never become misaligned.
   assign w_redirectPc = {redirect_pc[31:2], redirect_pc[1:0] & 2'b00};

   always_comb begin
      w_stateNext = r_state;
      if (r_state == RUN && halt) begin
         w_stateNext = HALT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Priority within RUN is halt > redirect > stall > normal fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_instr      <= 32'h0;
         r_pc4        <= 32'h0;
         r_valid      <= 1'b0;
         r_fetchCount <= 32'h0;
      end else if (r_state == RUN) begin
         if (halt) begin
            r_instr <= 32'h0;
            r_valid <= 1'b0;
         end else if (redirect) begin
            r_pc    <= w_redirectPc;
            r_instr <= 32'h0;
            r_valid <= 1'b0;
         end else if (!stall) begin
            r_pc         <= w_pcPlus4;
            r_instr      <= rom_data;
            r_pc4        <= w_pcPlus4;
            r_valid      <= 1'b1;
            r_fetchCount <= r_fetchCount + 32'd1;
         end
      end else begin
         r_instr <= 32'h0;
         r_valid <= 1'b0;
      end
   end

   assign rom_addr    = r_pc[ADDR_W+1:2];
   assign pc          = r_pc;
   assign if_id_instr = r_instr;
   assign if_id_pc4   = r_pc4;
   assign if_id_valid = r_valid;
   assign halted      = (r_state == HALT);
   assign fetch_count = r_fetchCount;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: free run, stall, redirect, halt, ROM wrap and reset mid-stream.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rom_addr;
   logic [31:0] rom_data;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;
   logic [31:0] fetch_count;

   logic [31:0] rom [1024];
   int          checks = 0;
   int          errors = 0;

   localparam logic [31:0] ROM16   = 32'h2400_1234;
   localparam logic [31:0] ROM1023 = 32'h3C1F_FFFF;

   inst_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
      .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   assign rom_data = rom[rom_addr];

   task automatic applyStimulus(input logic iRst, input logic iStall, input logic iRedirect,
                                input logic [31:0] iRedirectPc, input logic iHalt);
      rst         = iRst;
      stall       = iStall;
      redirect    = iRedirect;
      redirect_pc = iRedirectPc;
      halt        = iHalt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic [31:0] ePc, input logic [31:0] eInstr,
                             input logic [31:0] ePc4, input logic eValid, input logic [31:0] eCount,
                             input logic eHalted);
      checkOutput({tag, ".pc"},       pc,                  ePc);
      checkOutput({tag, ".rom_addr"}, 32'(rom_addr),       32'(ePc[11:2]));
      checkOutput({tag, ".instr"},    if_id_instr,         eInstr);
      checkOutput({tag, ".pc4"},      if_id_pc4,           ePc4);
      checkOutput({tag, ".valid"},    32'(if_id_valid),    32'(eValid));
      checkOutput({tag, ".count"},    fetch_count,         eCount);
      checkOutput({tag, ".halted"},   32'(halted),         32'(eHalted));
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 + 32'(i);
      rom[0]    = 32'h2001_0005;
      rom[1]    = 32'h2002_000A;
      rom[2]    = 32'h0022_1820;
      rom[3]    = 32'h0000_000C;
      rom[16]   = ROM16;
      rom[1023] = ROM1023;

      $display("[TB] reset and free run");
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      tick();
      checkState("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("run1", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 32'd1, 1'b0);
      tick();
      checkState("run2", 32'h8, 32'h2002_000A, 32'h8, 1'b1, 32'd2, 1'b0);

      $display("[TB] stall");
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkState("stall", 32'h8, 32'h2002_000A, 32'h8, 1'b1, 32'd2, 1'b0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("unstall", 32'hC, 32'h0022_1820, 32'hC, 1'b1, 32'd3, 1'b0);
      tick();
      checkState("run4", 32'h10, 32'h0000_000C, 32'h10, 1'b1, 32'd4, 1'b0);

      $display("[TB] redirect");
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0043, 1'b0);
      tick();
      checkState("redir", 32'h40, 32'h0, 32'h10, 1'b0, 32'd4, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("redirFetch", 32'h44, ROM16, 32'h44, 1'b1, 32'd5, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0043, 1'b0);
      tick();
      checkState("redirStall", 32'h40, 32'h0, 32'h44, 1'b0, 32'd5, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("redirStallFetch", 32'h44, ROM16, 32'h44, 1'b1, 32'd6, 1'b0);

      $display("[TB] halt");
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b0);
      tick();
      checkState("toPc20", 32'h20, 32'h0, 32'h44, 1'b0, 32'd6, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
      tick();
      checkState("halt", 32'h20, 32'h0, 32'h44, 1'b0, 32'd6, 1'b1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, i[0], i[1], 32'h0000_0200, 1'b0);
         tick();
         checkState("halted", 32'h20, 32'h0, 32'h44, 1'b0, 32'd6, 1'b1);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("haltReset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);

      $display("[TB] rom address wrap");
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0FFC, 1'b0);
      tick();
      checkState("wrapTarget", 32'hFFC, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("wrap1", 32'h1000, ROM1023, 32'h1000, 1'b1, 32'd1, 1'b0);
      tick();
      checkState("wrap2", 32'h1004, 32'h2001_0005, 32'h1004, 1'b1, 32'd2, 1'b0);

      $display("[TB] reset mid-stream");
      tick();
      tick();
      tick();
      checkState("preReset", 32'h1010, 32'h0000_000C, 32'h1010, 1'b1, 32'd5, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("preResetStall", 32'h1010, 32'h0000_000C, 32'h1010, 1'b1, 32'd5, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("midReset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);

      $display("[TB] 32-bit pc wrap");
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      tick();
      checkState("pcTop", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("pcWrap", 32'h0, ROM1023, 32'h0, 1'b1, 32'd1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
